// File: rtl/funnel_shifter_pkg.sv
// Shared types and helpers for the funnel shifter: mode encodings and
// shift-amount width derivation.
package funnel_shifter_pkg;

  typedef enum logic [2:0] {
    SHR_LOG = 3'b000,
    SHL_LOG = 3'b001,
    SHR_ARI = 3'b010,
    SHL_ARI = 3'b011,
    ROR     = 3'b100,
    ROL     = 3'b101
  } shift_mode_e;

  // Number of bits needed to encode a shift of 0..width-1.
  function automatic int unsigned calc_amt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/funnel_window.sv
// Combinational window extractor: picks WIDTH bits out of {hi, lo}, sliding
// right by amt (dir=0) or left by amt (dir=1).
module funnel_window
  import funnel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned AMT_W = calc_amt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] win_o
);

  localparam int unsigned BaseW = AMT_W + 1;

  logic [2*WIDTH-1:0] funnel;
  logic [BaseW-1:0]   base;

  assign funnel = {hi_i, lo_i};

  // A left window of F<<amt starts at bit WIDTH-amt of F; a right window at amt.
  always_comb begin
    if (dir_i) begin
      base = BaseW'(WIDTH) - {1'b0, amt_i};
    end else begin
      base = {1'b0, amt_i};
    end
  end

  assign win_o = funnel[base +: WIDTH];

endmodule

// File: rtl/funnel_shifter.sv
// Registered shift/rotate unit: decodes mode into funnel operands and
// captures the selected window one clock after the inputs.
module funnel_shifter
  import funnel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned AMT_W = calc_amt_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic [2:0]       mode_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] hi, lo, win;
  logic [AMT_W-1:0] amt;
  logic             dir;
  logic [WIDTH-1:0] y_d, y_q;

  always_comb begin
    hi  = '0;
    lo  = a_i;
    dir = 1'b0;
    amt = amt_i;
    case (shift_mode_e'(mode_i))
      SHR_LOG: hi = '0;
      SHL_LOG, SHL_ARI: begin
        hi  = a_i;
        lo  = '0;
        dir = 1'b1;
      end
      SHR_ARI: hi = {WIDTH{a_i[WIDTH-1]}};
      ROR:     hi = a_i;
      ROL: begin
        hi  = a_i;
        dir = 1'b1;
      end
      // Reserved encodings: a right window of {0, a} at offset 0 is a itself.
      default: amt = '0;
    endcase
  end

  funnel_window #(
    .WIDTH (WIDTH)
  ) u_window (
    .hi_i  (hi),
    .lo_i  (lo),
    .amt_i (amt),
    .dir_i (dir),
    .win_o (win)
  );

  assign y_d = win;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: tb/tb_funnel_shifter.sv
// Directed and seeded-random checks of funnel_shifter at WIDTH=4 and WIDTH=8.
module tb_funnel_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a4 = '0;
  logic [1:0] amt4 = '0;
  logic [2:0] mode4 = '0;
  logic [3:0] y4;
  logic [7:0] a8 = '0;
  logic [2:0] amt8 = '0;
  logic [2:0] mode8 = '0;
  logic [7:0] y8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  funnel_shifter #(.WIDTH(4)) u_dut4 (
    .clk_i  (clk),
    .rst_i  (rst),
    .a_i    (a4),
    .amt_i  (amt4),
    .mode_i (mode4),
    .y_o    (y4)
  );

  funnel_shifter #(.WIDTH(8)) u_dut8 (
    .clk_i  (clk),
    .rst_i  (rst),
    .a_i    (a8),
    .amt_i  (amt8),
    .mode_i (mode8),
    .y_o    (y8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge, return 1ns after the capturing edge.
  task automatic step4(input logic [3:0] a, input logic [1:0] amt, input logic [2:0] mode);
    @(negedge clk);
    a4    = a;
    amt4  = amt;
    mode4 = mode;
    @(posedge clk);
    #1;
  endtask

  // Bit-by-bit reference, independent of the funnel construction.
  function automatic logic [7:0] ref_shift(input logic [7:0] a, input int amt,
                                           input logic [2:0] mode, input int w);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < w; i++) begin
      case (mode)
        3'b000: if (i + amt < w) y[i] = a[i+amt];
        3'b001, 3'b011: if (i >= amt) y[i] = a[i-amt];
        3'b010: y[i] = (i + amt < w) ? a[i+amt] : a[w-1];
        3'b100: y[i] = a[(i+amt)%w];
        3'b101: y[i] = a[(i-amt+w)%w];
        default: y[i] = a[i];
      endcase
    end
    return y;
  endfunction

  logic [3:0] exp_lsr [4] = '{4'b1101, 4'b0110, 4'b0011, 4'b0001};
  logic [3:0] exp_lsl [4] = '{4'b1101, 4'b1010, 4'b0100, 4'b1000};
  logic [3:0] exp_asr [4] = '{4'b1101, 4'b1110, 4'b1111, 4'b1111};
  logic [3:0] exp_asr_p [4] = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
  logic [3:0] exp_ror [4] = '{4'b1101, 4'b1110, 4'b0111, 4'b1011};
  logic [3:0] exp_rol [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    logic [7:0] e4, e8, prev4;

    // Reset held across edges with toggling inputs.
    #1 rst = 1'b1;
    #1;
    chk("rst_async4", {4'b0, y4}, 8'h00);
    chk("rst_async8", y8, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a4 = 4'(i * 5 + 3);
      mode4 = 3'(i);
      amt4 = 2'(i);
      a8 = 8'(i * 37 + 1);
      @(posedge clk);
      #1;
      chk("rst_hold4", {4'b0, y4}, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    step4(4'b1101, 2'd0, 3'b000);
    chk("first_after_rst", {4'b0, y4}, 8'h0d);

    for (int s = 0; s < 4; s++) begin
      step4(4'b1101, 2'(s), 3'b000);
      chk($sformatf("lsr_%0d", s), {4'b0, y4}, {4'b0, exp_lsr[s]});
      step4(4'b1101, 2'(s), 3'b001);
      chk($sformatf("lsl_%0d", s), {4'b0, y4}, {4'b0, exp_lsl[s]});
      step4(4'b1101, 2'(s), 3'b010);
      chk($sformatf("asr_neg_%0d", s), {4'b0, y4}, {4'b0, exp_asr[s]});
      step4(4'b0101, 2'(s), 3'b010);
      chk($sformatf("asr_pos_%0d", s), {4'b0, y4}, {4'b0, exp_asr_p[s]});
      step4(4'b1101, 2'(s), 3'b011);
      chk($sformatf("asl_%0d", s), {4'b0, y4}, {4'b0, exp_lsl[s]});
      step4(4'b1101, 2'(s), 3'b100);
      chk($sformatf("ror_%0d", s), {4'b0, y4}, {4'b0, exp_ror[s]});
      step4(4'b1101, 2'(s), 3'b101);
      chk($sformatf("rol_%0d", s), {4'b0, y4}, {4'b0, exp_rol[s]});
      step4(4'b1001, 2'(s), 3'b110);
      chk($sformatf("rsv110_%0d", s), {4'b0, y4}, 8'h09);
      step4(4'b1001, 2'(s), 3'b111);
      chk($sformatf("rsv111_%0d", s), {4'b0, y4}, 8'h09);
    end

    // Latency: new inputs must not show until the next rising edge.
    step4(4'b1101, 2'd1, 3'b100);
    prev4 = {4'b0, y4};
    @(negedge clk);
    a4 = 4'b0011;
    amt4 = 2'd2;
    mode4 = 3'b001;
    #1;
    chk("latency_hold", {4'b0, y4}, 8'h0e);
    chk("latency_prev", {4'b0, y4}, prev4);
    @(posedge clk);
    #1;
    chk("latency_update", {4'b0, y4}, 8'h0c);

    // Seeded random regression on both widths, with a mid-stream reset.
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      a4 = 4'($urandom);
      amt4 = 2'($urandom);
      mode4 = 3'($urandom);
      a8 = 8'($urandom);
      amt8 = 3'($urandom);
      mode8 = 3'($urandom);
      e4 = ref_shift({4'b0, a4}, int'(amt4), mode4, 4);
      e8 = ref_shift(a8, int'(amt8), mode8, 8);
      @(posedge clk);
      #1;
      chk($sformatf("rand4_%0d", k), {4'b0, y4}, e4);
      chk($sformatf("rand8_%0d", k), y8, e8);
      if (k == 30) begin
        #1 rst = 1'b1;
        #1;
        chk("midrst4", {4'b0, y4}, 8'h00);
        chk("midrst8", y8, 8'h00);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
